// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO side bundle of the round-robin write arbiter.
// master = arbiter view, slave = producers plus FIFO view.
`timescale 1ns/1ps
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        fifo_full;
  logic                        fifo_wrtEn;
  logic [DATA_W-1:0]           fifo_wrtData;
  logic [$clog2(NUM_REQ)-1:0]  grant_id;
  logic                        busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wrtEn, fifo_wrtData, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wrtEn, fifo_wrtData, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bursts of up to MAX_BURST beats and stalling on FIFO full.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [GW-1:0]   cand;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] slice [NUM_REQ];
  logic            in_burst, owner_valid, xfer, found;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  assign in_burst    = (state_q == BURST);
  assign owner_valid = bus.req_valid[grant_id_q];
  assign xfer        = in_burst & owner_valid & ~bus.fifo_full;

  // Only the owner ever sees ready, and never while the FIFO is full.
  always_comb begin
    bus.req_ready = '0;
    if (in_burst) bus.req_ready[grant_id_q] = ~bus.fifo_full;
  end

  assign bus.fifo_wrtEn   = xfer;
  assign bus.fifo_wrtData = in_burst ? slice[grant_id_q] : '0;
  assign bus.grant_id     = grant_id_q;
  assign bus.busy         = in_burst;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    cand         = '0;
    found        = 1'b0;
    case (state_q)
      IDLE: begin
        // Search starts just past the previous owner, so it drops to lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
          if (!found && bus.req_valid[cand]) begin
            found        = 1'b1;
            grant_id_d   = cand;
            last_grant_d = cand;
          end
        end
        if (found) begin
          state_d    = BURST;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == BW'(MAX_BURST - 1)) state_d = IDLE;
        end else if (!owner_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers are data queues, expectations come from
// a transaction-level round-robin model plus a simple FIFO occupancy counter.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 128;

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] pq [N][$];
  bit            pv [N];
  bit [N-1:0]    en_mask;
  bit            hold_mode;
  bit            drain_on;
  int            full_pct;
  int            fifo_cnt;
  int            wr_count;
  int            busy_cycles;
  int            wr_full;
  int            grants [$];

  bit            m_busy;
  int            m_owner;
  int            m_last;
  int            m_gid;
  int            m_beats;

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic int g_at(input int i);
    return (i < grants.size()) ? grants[i] : -1;
  endfunction

  task automatic raise_all();
    for (int i = 0; i < N; i++)
      if (en_mask[i] && pq[i].size() > 0) pv[i] = 1'b1;
  endtask

  // One clock: drive at negedge, check combinational outputs, then advance the model.
  task automatic apply_stimulus();
    bit           full_now;
    bit           exp_en;
    logic [N-1:0] exp_ready;
    int           xfer;
    int           pick;
    @(negedge clk);
    full_now = (fifo_cnt >= DEPTH) || ($urandom_range(0, 99) < full_pct);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]            = pv[i];
      bus.req_data[i*DW +: DW]    = pv[i] ? pq[i][0] : DW'($urandom);
    end
    bus.fifo_full = full_now;
    #1;
    exp_ready = '0;
    exp_en    = 1'b0;
    if (m_busy) begin
      if (!full_now) exp_ready[m_owner] = 1'b1;
      exp_en = pv[m_owner] && !full_now;
    end
    check_output("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check_output("fifo_wrtEn", 32'(bus.fifo_wrtEn), 32'(exp_en));
    check_output("busy", 32'(bus.busy), 32'(m_busy));
    check_output("grant_id", 32'(bus.grant_id), 32'(m_gid));
    if (exp_en) check_output("fifo_wrtData", 32'(bus.fifo_wrtData), 32'(pq[m_owner][0]));
    if (bus.busy) busy_cycles++;
    if (bus.fifo_full && bus.fifo_wrtEn) wr_full++;

    xfer = -1;
    if (!m_busy) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && pv[(m_last + k) % N]) pick = (m_last + k) % N;
      if (pick >= 0) begin
        m_busy = 1'b1; m_owner = pick; m_last = pick; m_gid = pick; m_beats = 0;
        grants.push_back(pick);
      end
    end else if (exp_en) begin
      xfer = m_owner;
      m_beats++;
      wr_count++;
      fifo_cnt++;
      if (m_beats == MB) m_busy = 1'b0;
    end else if (!pv[m_owner]) begin
      m_busy = 1'b0;
    end
    if (drain_on && fifo_cnt > 0 && $urandom_range(0, 1) == 1) fifo_cnt--;

    // Producers only change valid between beats: after a transfer or while idle.
    if (xfer >= 0) begin
      void'(pq[xfer].pop_front());
      pv[xfer] = (pq[xfer].size() > 0) && (hold_mode || $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < N; i++)
      if (!pv[i] && i != xfer && en_mask[i] && pq[i].size() > 0 && (hold_mode || $urandom_range(0, 1) == 1))
        pv[i] = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) apply_stimulus();
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check_output({tag, "_wrtEn"}, 32'(bus.fifo_wrtEn), 32'd0);
    check_output({tag, "_wrtData"}, 32'(bus.fifo_wrtData), 32'd0);
    check_output({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_output({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
    m_busy = 1'b0; m_last = N - 1; m_gid = 0; m_beats = 0;
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  initial begin
    bit reached;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    en_mask = '0; hold_mode = 1'b1; drain_on = 1'b1; full_pct = 0;
    fifo_cnt = 0; wr_count = 0; busy_cycles = 0; wr_full = 0;
    m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_gid = 0; m_beats = 0;
    apply_reset("rst_init");

    // Single producer, three beats then valid drops.
    en_mask = 4'b0001;
    pq[0].push_back(8'h11); pq[0].push_back(8'h22); pq[0].push_back(8'h33);
    raise_all();
    busy_cycles = 0; wr_count = 0; grants.delete();
    run_cycles(8);
    check_output("t1_busy_cycles", 32'(busy_cycles), 32'd4);
    check_output("t1_writes", 32'(wr_count), 32'd3);
    check_output("t1_grant", 32'(g_at(0)), 32'd0);

    // last_grant=1 then 1001 requests: 3 first, then wrap to 0.
    en_mask = 4'b0010;
    pq[1].push_back(DW'($urandom));
    raise_all();
    run_cycles(6);
    grants.delete();
    en_mask = 4'b1001;
    pq[0].push_back(DW'($urandom)); pq[3].push_back(DW'($urandom));
    raise_all();
    run_cycles(10);
    check_output("t4_first", 32'(g_at(0)), 32'd3);
    check_output("t4_wrap", 32'(g_at(1)), 32'd0);

    // All requesters continuously valid from reset.
    apply_reset("rst_t2");
    en_mask = 4'b1111;
    for (int i = 0; i < N; i++) repeat (8) pq[i].push_back(DW'($urandom));
    raise_all();
    grants.delete(); wr_count = 0; fifo_cnt = 0;
    run_cycles(25);
    check_output("t2_writes_25cyc", 32'(wr_count), 32'd20);
    check_output("t2_g0", 32'(g_at(0)), 32'd0);
    check_output("t2_g1", 32'(g_at(1)), 32'd1);
    check_output("t2_g2", 32'(g_at(2)), 32'd2);
    check_output("t2_g3", 32'(g_at(3)), 32'd3);
    check_output("t2_g4", 32'(g_at(4)), 32'd0);
    run_cycles(20);

    // No draining: FIFO fills to exactly DEPTH and nothing is written while full.
    drain_on = 1'b0; fifo_cnt = 0; wr_full = 0;
    for (int i = 0; i < N; i++) repeat (40) pq[i].push_back(DW'($urandom));
    raise_all();
    run_cycles(220);
    check_output("t6_fifo_level", 32'(fifo_cnt), 32'(DEPTH));
    check_output("t6_write_while_full", 32'(wr_full), 32'd0);
    drain_on = 1'b1;
    run_cycles(300);

    // Randomised producers and random full stalls.
    hold_mode = 1'b0; full_pct = 20;
    for (int r = 0; r < 40; r++) begin
      pq[$urandom_range(0, N-1)].push_back(DW'($urandom));
      pq[$urandom_range(0, N-1)].push_back(DW'($urandom));
      run_cycles(15);
    end
    check_output("rand_write_while_full", 32'(wr_full), 32'd0);

    // Flush, then reset in the middle of a req2 burst.
    hold_mode = 1'b1; full_pct = 0; en_mask = 4'b1111;
    run_cycles(300);
    en_mask = 4'b0100;
    repeat (4) pq[2].push_back(DW'($urandom));
    raise_all();
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      apply_stimulus();
      if (m_busy && m_owner == 2 && m_beats == 2) reached = 1'b1;
    end
    check_output("t5_reach_beat2", 32'(reached), 32'd1);
    apply_reset("rst_mid");
    check_output("t5_owned_beats", 32'(pq[2].size()), 32'd2);
    en_mask = 4'b1111;
    for (int i = 0; i < N; i++) repeat (4) pq[i].push_back(DW'($urandom));
    raise_all();
    grants.delete();
    run_cycles(12);
    check_output("t5_first_grant", 32'(g_at(0)), 32'd0);
    run_cycles(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
